// File: rtl/store_merge_unit.sv
// Store merge unit: sends byte and word stores to a word-wide RAM that has no byte enables.
// Latency: word store writes in cycle 1 and done is in cycle 2; byte store reads in cycle 1, writes in cycle 2, done is in cycle 3.
// Backpressure: busy_o is high while a store is in flight, and req_i is ignored (not queued) until it drops.
//
// Ports:
//   clk_i, rst_n_i        : clock and asynchronous active-low reset
//   req_i, size_i         : store request; size_i=1 byte store (lane addr_i[1:0]), 0 word store
//   addr_i, wdata_i       : byte address and store data (byte stores use only wdata_i[7:0])
//   busy_o                : a store is in progress
//   done_o, misaligned_o  : completion pulse, plus a flag for word stores with addr[1:0] != 0
//   mem_*                 : synchronous RAM interface (read data arrives the cycle after mem_re_o)
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              misaligned_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic              mem_re_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q;
    logic              misaligned_q;
    logic [31:0]       merged;

    // Next state, request latching and RAM strobes
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_re_o = 1'b0;
        mem_we_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    size_d  = size_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    state_d = size_i ? ST_READ : ST_WRITE;
                end
            end
            ST_READ: begin
                mem_re_o = 1'b1;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we_o = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In WRITE, mem_rdata_i holds the word fetched during READ. Overwrite only the
    // addressed lane (little-endian: lane 0 is bits 7:0).
    always_comb begin
        merged = mem_rdata_i;
        case (addr_q[1:0])
            2'd0: merged[7:0]   = wdata_q[7:0];
            2'd1: merged[15:8]  = wdata_q[7:0];
            2'd2: merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
        endcase
    end

    // Word stores drop addr[1:0], so a misaligned word store is aligned down
    assign mem_addr_o   = addr_q[ADDR_W-1:2];
    assign mem_wdata_o  = size_q ? merged : wdata_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign misaligned_o = misaligned_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            size_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            // Done and misaligned are high only in the first IDLE cycle after WRITE
            done_q       <= (state_q == ST_WRITE);
            misaligned_q <= (state_q == ST_WRITE) && !size_q && (addr_q[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Testbench for store_merge_unit: a behavioural RAM plus a reference word array.
// Latency: each store is checked cycle by cycle from its accept edge.
// Backpressure: some requests keep req high, so the next store is accepted in the done cycle.
module tb_store_merge_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;

    int          n_vec;
    int          n_err;
    int          cyc;

    // TB-side RAM (64 words) and the reference model of its contents
    logic [31:0] ram [0:63];
    logic [31:0] ref_mem [0:63];
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_dat;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_i        (req),
        .size_i       (size),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .busy_o       (busy),
        .done_o       (done),
        .misaligned_o (misaligned),
        .mem_addr_o   (mem_addr),
        .mem_re_o     (mem_re),
        .mem_rdata_i  (mem_rdata),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) ram[ld_idx] <= ld_dat;
        else if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr[5:0]];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered at a negedge with the DUT idle. Returns at the negedge of the done cycle.
    task automatic run_store(input logic sz, input logic [7:0] ad, input logic [31:0] wd,
                             input bit hold);
        logic [5:0]  widx;
        logic [31:0] exp;
        widx = ad[7:2];
        exp  = ref_mem[widx];
        if (sz) exp[8*ad[1:0] +: 8] = wd[7:0];
        else    exp = wd;
        check_val("idle_busy", {31'b0, busy}, 32'd0);
        req = 1'b1; size = sz; addr = {24'b0, ad}; wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the request inputs; the latched copy must be used
        req = hold; size = ~sz; addr = $urandom; wdata = $urandom;
        if (sz) begin
            @(negedge clk);
            check_val("rd_re", {31'b0, mem_re}, 32'd1);
            check_val("rd_we", {31'b0, mem_we}, 32'd0);
            check_val("rd_busy", {31'b0, busy}, 32'd1);
            check_val("rd_done", {31'b0, done}, 32'd0);
            check_val("rd_addr", 32'(mem_addr), {26'b0, widx});
        end
        @(negedge clk);
        check_val("wr_we", {31'b0, mem_we}, 32'd1);
        check_val("wr_re", {31'b0, mem_re}, 32'd0);
        check_val("wr_busy", {31'b0, busy}, 32'd1);
        check_val("wr_done", {31'b0, done}, 32'd0);
        check_val("wr_addr", 32'(mem_addr), {26'b0, widx});
        check_val("wr_data", mem_wdata, exp);
        @(negedge clk);
        check_val("done", {31'b0, done}, 32'd1);
        check_val("misaligned", {31'b0, misaligned}, {31'b0, (!sz && ad[1:0] != 2'b00)});
        check_val("done_busy", {31'b0, busy}, 32'd0);
        check_val("done_we", {31'b0, mem_we}, 32'd0);
        check_val("done_re", {31'b0, mem_re}, 32'd0);
        ref_mem[widx] = exp;
        check_val("ram_word", ram[widx], exp);
    endtask

    initial begin
        int s;
        int e;
        n_vec = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0; req = 1'b0; size = 1'b0; addr = '0; wdata = '0;
        ld_en = 1'b0; ld_idx = '0; ld_dat = '0;
        #1;
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_mis", {31'b0, misaligned}, 32'd0);
        check_val("rst_re", {31'b0, mem_re}, 32'd0);
        check_val("rst_we", {31'b0, mem_we}, 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        check_val("rst_wdata", mem_wdata, 32'd0);

        // Preload the RAM while reset is held
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ld_en  = 1'b1;
            ld_idx = i[5:0];
            ld_dat = (i == 0) ? 32'h11223344 : (i == 4) ? 32'h0 : $urandom;
            ref_mem[i] = ld_dat;
        end
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned word store
        run_store(1'b0, 8'h10, 32'hDEADBEEF, 1'b0);
        // Byte stores to every lane; upper data bits must not leak
        run_store(1'b1, 8'h00, 32'hFFFFFFAA, 1'b0);
        check_val("lane0", ram[0], 32'h112233AA);
        run_store(1'b1, 8'h01, 32'hFFFFFFBB, 1'b0);
        check_val("lane1", ram[0], 32'h1122BBAA);
        run_store(1'b1, 8'h02, 32'hFFFFFFCC, 1'b0);
        check_val("lane2", ram[0], 32'h11CCBBAA);
        run_store(1'b1, 8'h03, 32'hFFFFFFDD, 1'b0);
        check_val("lane3", ram[0], 32'hDDCCBBAA);
        // Misaligned word store is aligned down
        run_store(1'b0, 8'h07, 32'h12345678, 1'b0);
        check_val("mis_word", ram[1], 32'h12345678);

        // Back-to-back with req held: byte, word, byte, word to the same word = 10 cycles
        @(negedge clk);
        s = cyc;
        run_store(1'b1, 8'h09, 32'h000000A1, 1'b1);
        run_store(1'b0, 8'h08, 32'hCAFEF00D, 1'b1);
        run_store(1'b1, 8'h0A, 32'h000000B2, 1'b1);
        run_store(1'b0, 8'h0C, 32'h0BADC0DE, 1'b0);
        e = cyc;
        check_val("b2b_cycles", e - s, 32'd10);
        check_val("b2b_word2", ram[2], 32'hCAB2F00D);

        // Reset while a byte store is in READ
        @(negedge clk);
        req = 1'b1; size = 1'b1; addr = 32'h20; wdata = 32'h55;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check_val("mid_re", {31'b0, mem_re}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_re", {31'b0, mem_re}, 32'd0);
        check_val("arst_we", {31'b0, mem_we}, 32'd0);
        check_val("arst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("arst_nodone", {31'b0, done}, 32'd0);
        end
        check_val("arst_ram", ram[8], ref_mem[8]);
        run_store(1'b1, 8'h21, 32'h00000066, 1'b0);

        // Random mix, some held back-to-back
        for (int i = 0; i < 60; i++) begin
            run_store(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom,
                      bit'($urandom_range(0, 1)));
        end
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 64; i++) check_val("final_ram", ram[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
